dram_arbiter: RTL and testbench

N-port request arbiter in the user clock domain, placed between several requesters (e.g. instruction fetch, data cache, DMA) and the single user-side command/response interface of the DRAM wrapper. Multiplexes read/write commands onto one channel under round-robin arbitration, tracks outstanding reads in an in-order tag FIFO, and routes each returned read beat back to the port that issued it. Successor to the single-requester wrapper interface: generalised in port count and outstanding-read depth, with response routing and protocol error detection.

---
 rtl/dram_arbiter.sv | 135 +++++++++++++
 tb/tb_dram_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// N-port round-robin command arbiter in front of the DRAM wrapper, with an in-order read tag FIFO.
// Define DRAM_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (lowest index wins).
module dram_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 128,
  parameter int MASK_WIDTH     = 16,
  parameter int TAG_ADDR_WIDTH = 3
) (
  input  logic                           clk,
  input  logic                           i_rst,
  input  logic [NUM_PORTS-1:0]           i_p_ren,
  input  logic [NUM_PORTS-1:0]           i_p_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] i_p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_p_data,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0] i_p_mask,
  output logic [NUM_PORTS-1:0]           o_p_grant,
  output logic [DATA_WIDTH-1:0]          o_p_data,
  output logic [NUM_PORTS-1:0]           o_p_data_valid,
  output logic                           o_dram_ren,
  output logic                           o_dram_wen,
  output logic [ADDR_WIDTH-1:0]          o_dram_addr,
  output logic [DATA_WIDTH-1:0]          o_dram_data,
  output logic [MASK_WIDTH-1:0]          o_dram_mask,
  input  logic                           i_dram_busy,
  input  logic [DATA_WIDTH-1:0]          i_dram_data,
  input  logic                           i_dram_data_valid,
  output logic [TAG_ADDR_WIDTH:0]        o_outstanding,
  output logic                           o_err
);

  localparam int DEPTH = 2 ** TAG_ADDR_WIDTH;
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(NUM_PORTS - 1);

  logic                      fifo_full;
  logic [NUM_PORTS-1:0]      eligible;
  logic [2*NUM_PORTS-1:0]    elig_dbl;
  logic [NUM_PORTS-1:0]      elig_rot;
  logic [PTR_W-1:0]          search_start;
  logic [PTR_W-1:0]          winner;
  logic                      found;
  logic                      grant_any;
  logic                      winner_writes;
  logic                      push;
  logic                      pop;
  logic [TAG_ADDR_WIDTH-1:0] wr_ptr;
  logic [TAG_ADDR_WIDTH-1:0] rd_ptr;
  logic [PTR_W-1:0]          tag_mem [DEPTH];

  // Reads are held off once every tag slot is in use; writes never need a tag.
  assign fifo_full = (o_outstanding == (TAG_ADDR_WIDTH+1)'(DEPTH));
  assign eligible  = i_p_wen | (i_p_ren & {NUM_PORTS{~fifo_full}});

`ifdef DRAM_ARB_FIXED_PRIO_EN
  assign search_start = '0;
`else
  logic [PTR_W-1:0] rr_ptr;

  always_ff @(posedge clk) begin
    if (i_rst)
      rr_ptr <= '0;
    else if (grant_any)
      rr_ptr <= (winner == LAST_PORT) ? '0 : winner + 1'b1;
  end

  assign search_start = rr_ptr;
`endif

  // Rotate so bit 0 is the port at the search start, then take the first set bit.
  assign elig_dbl = {eligible, eligible} >> search_start;
  assign elig_rot = elig_dbl[NUM_PORTS-1:0];

  always_comb begin
    int sum;
    found  = 1'b0;
    winner = '0;
    sum    = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && elig_rot[i]) begin
        found = 1'b1;
        sum   = int'(search_start) + i;
        if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
        winner = PTR_W'(sum);
      end
    end
  end

  assign grant_any     = found & ~i_dram_busy & ~i_rst;
  assign winner_writes = i_p_wen[winner];
  assign o_p_grant     = grant_any ? (NUM_PORTS'(1) << winner) : '0;
  assign o_dram_wen    = grant_any & winner_writes;
  assign o_dram_ren    = grant_any & ~winner_writes;
  assign o_dram_addr   = i_p_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
  assign o_dram_data   = i_p_data[winner*DATA_WIDTH +: DATA_WIDTH];
  assign o_dram_mask   = i_p_mask[winner*MASK_WIDTH +: MASK_WIDTH];

  assign push = o_dram_ren;
  assign pop  = i_dram_data_valid & (o_outstanding != '0);

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      o_outstanding <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   o_outstanding <= o_outstanding + 1'b1;
        2'b01:   o_outstanding <= o_outstanding - 1'b1;
        default: o_outstanding <= o_outstanding;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= winner;
  end

  // Return path: one register stage, routed by the tag at the FIFO head.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_p_data       <= '0;
      o_p_data_valid <= '0;
      o_err          <= 1'b0;
    end else begin
      o_p_data_valid <= pop ? (NUM_PORTS'(1) << tag_mem[rd_ptr]) : '0;
      if (i_dram_data_valid) o_p_data <= i_dram_data;
      if (i_dram_data_valid && !pop) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_dram_arbiter;

  localparam int NP    = 3;
  localparam int AW    = 27;
  localparam int DW    = 128;
  localparam int MW    = 16;
  localparam int TW    = 3;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             i_rst;
  logic [NP-1:0]    i_p_ren, i_p_wen;
  logic [NP*AW-1:0] i_p_addr;
  logic [NP*DW-1:0] i_p_data;
  logic [NP*MW-1:0] i_p_mask;
  logic [NP-1:0]    o_p_grant;
  logic [DW-1:0]    o_p_data;
  logic [NP-1:0]    o_p_data_valid;
  logic             o_dram_ren, o_dram_wen;
  logic [AW-1:0]    o_dram_addr;
  logic [DW-1:0]    o_dram_data;
  logic [MW-1:0]    o_dram_mask;
  logic             i_dram_busy;
  logic [DW-1:0]    i_dram_data;
  logic             i_dram_data_valid;
  logic [TW:0]      o_outstanding;
  logic             o_err;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: rotating priority index, queue of port numbers for reads in flight, sticky error.
  int            m_rr = 0;
  int            m_tags[$];
  logic          m_err = 1'b0;
  logic          rand_fields = 1'b1;

  dram_arbiter #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TAG_ADDR_WIDTH(TW)
  ) dut (
    .clk(clk), .i_rst(i_rst),
    .i_p_ren(i_p_ren), .i_p_wen(i_p_wen), .i_p_addr(i_p_addr), .i_p_data(i_p_data), .i_p_mask(i_p_mask),
    .o_p_grant(o_p_grant), .o_p_data(o_p_data), .o_p_data_valid(o_p_data_valid),
    .o_dram_ren(o_dram_ren), .o_dram_wen(o_dram_wen), .o_dram_addr(o_dram_addr),
    .o_dram_data(o_dram_data), .o_dram_mask(o_dram_mask), .i_dram_busy(i_dram_busy),
    .i_dram_data(i_dram_data), .i_dram_data_valid(i_dram_data_valid),
    .o_outstanding(o_outstanding), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check the combinational command path, then the registered outputs.
  task automatic apply_stimulus(input logic [NP-1:0] ren, input logic [NP-1:0] wen,
                                input logic busy, input logic dv, output logic [NP-1:0] g);
    int won;
    logic [NP-1:0] exp_valid;
    logic [DW-1:0] exp_data;
    logic          rst_now;
    i_p_ren = ren;
    i_p_wen = wen;
    i_dram_busy = busy;
    i_dram_data_valid = dv;
    i_dram_data = {$urandom, $urandom, $urandom, $urandom};
    if (rand_fields) begin
      for (int k = 0; k < NP; k++) begin
        i_p_addr[k*AW +: AW] = AW'($urandom);
        i_p_data[k*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
        i_p_mask[k*MW +: MW] = MW'($urandom);
      end
    end
    #4;
    won = -1;
    if (!busy && !i_rst) begin
      for (int i = 0; i < NP; i++) begin
        int k;
        k = (m_rr + i) % NP;
        if (won < 0 && (wen[k] || (ren[k] && m_tags.size() < DEPTH))) won = k;
      end
    end
    g = o_p_grant;
    check_output("grant", o_p_grant, (won >= 0) ? DW'(1) << won : '0);
    check_output("dram_wen", o_dram_wen, (won >= 0) ? wen[won] : 1'b0);
    check_output("dram_ren", o_dram_ren, (won >= 0) ? !wen[won] : 1'b0);
    if (won >= 0) begin
      check_output("dram_addr", o_dram_addr, i_p_addr[won*AW +: AW]);
      check_output("dram_data", o_dram_data, i_p_data[won*DW +: DW]);
      check_output("dram_mask", o_dram_mask, i_p_mask[won*MW +: MW]);
    end
    @(posedge clk);
    rst_now   = i_rst;
    exp_valid = '0;
    exp_data  = i_dram_data;
    if (rst_now) begin
      m_tags.delete();
      m_rr  = 0;
      m_err = 1'b0;
      exp_data = '0;
    end else begin
      if (dv) begin
        if (m_tags.size() > 0) exp_valid = NP'(1) << m_tags.pop_front();
        else m_err = 1'b1;
      end
      if (won >= 0) begin
        if (!wen[won]) m_tags.push_back(won);
        m_rr = (won + 1) % NP;
      end
    end
    #1;
    check_output("data_valid", o_p_data_valid, exp_valid);
    if (rst_now || exp_valid != '0) check_output("ret_data", o_p_data, exp_data);
    check_output("outstanding", o_outstanding, m_tags.size());
    check_output("err", o_err, m_err);
  endtask

  initial begin
    logic [NP-1:0] g;
    logic [NP-1:0] route_exp [4];
    logic [NP-1:0] rr_seq [4];
    i_rst = 1'b1;
    i_p_ren = '0; i_p_wen = '0; i_p_addr = '0; i_p_data = '0; i_p_mask = '0;
    i_dram_busy = 1'b0; i_dram_data = '0; i_dram_data_valid = 1'b0;
    @(posedge clk); #1;

    // Reset holds grants off even with requests present.
    apply_stimulus(3'b011, 3'b100, 1'b0, 1'b0, g);
    apply_stimulus(3'b000, 3'b000, 1'b0, 1'b0, g);
    check_output("rst_grant", g, '0);
    i_rst = 1'b0;

    $display("[TB] single port 0 write");
    rand_fields = 1'b0;
    i_p_addr[0 +: AW] = AW'(32'h10);
    i_p_data[0 +: DW] = {16{8'hA5}};
    i_p_mask[0 +: MW] = 16'hFFFF;
    apply_stimulus(3'b000, 3'b001, 1'b0, 1'b0, g);
    check_output("wr_grant", g, 3'b001);
    check_output("wr_outstanding", o_outstanding, 0);
    rand_fields = 1'b1;

    $display("[TB] round robin reads and return routing");
    i_rst = 1'b1;
    apply_stimulus(3'b000, 3'b000, 1'b0, 1'b0, g);
    i_rst = 1'b0;
    rr_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
    route_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(3'b011, 3'b000, 1'b0, 1'b0, g);
      check_output("rr_grant", g, rr_seq[i]);
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(3'b000, 3'b000, 1'b0, 1'b1, g);
      check_output("ret_route", o_p_data_valid, route_exp[i]);
    end

    $display("[TB] tag FIFO full");
    for (int i = 0; i < DEPTH; i++) apply_stimulus(3'b001, 3'b000, 1'b0, 1'b0, g);
    check_output("full_count", o_outstanding, DEPTH);
    apply_stimulus(3'b001, 3'b010, 1'b0, 1'b0, g);
    check_output("full_write_ok", g, 3'b010);
    apply_stimulus(3'b001, 3'b000, 1'b0, 1'b1, g);
    check_output("full_no_bypass", g, 3'b000);
    apply_stimulus(3'b001, 3'b000, 1'b0, 1'b0, g);
    check_output("full_read_after_pop", g, 3'b001);
    while (m_tags.size() > 0) apply_stimulus(3'b000, 3'b000, 1'b0, 1'b1, g);

    $display("[TB] busy stalls");
    apply_stimulus(3'b111, 3'b000, 1'b1, 1'b0, g);
    check_output("busy_grant", g, 3'b000);
    apply_stimulus(3'b111, 3'b000, 1'b1, 1'b0, g);
    apply_stimulus(3'b111, 3'b000, 1'b0, 1'b0, g);
    while (m_tags.size() > 0) apply_stimulus(3'b000, 3'b000, 1'b0, 1'b1, g);

    $display("[TB] return with nothing outstanding");
    i_rst = 1'b1;
    apply_stimulus(3'b000, 3'b000, 1'b0, 1'b0, g);
    i_rst = 1'b0;
    apply_stimulus(3'b000, 3'b000, 1'b0, 1'b1, g);
    check_output("err_set", o_err, 1'b1);
    check_output("err_no_valid", o_p_data_valid, 3'b000);
    for (int i = 0; i < 3; i++) apply_stimulus(3'b000, 3'b000, 1'b0, 1'b0, g);
    check_output("err_sticky", o_err, 1'b1);
    i_rst = 1'b1;
    apply_stimulus(3'b000, 3'b000, 1'b0, 1'b0, g);
    i_rst = 1'b0;
    check_output("err_cleared", o_err, 1'b0);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      logic [NP-1:0] ren, wen;
      logic busy, dv;
      ren  = NP'($urandom);
      wen  = NP'($urandom) & NP'($urandom);
      busy = ($urandom_range(0, 4) == 0);
      dv   = (m_tags.size() > 0) && ($urandom_range(0, 2) != 0);
      i_rst = ($urandom_range(0, 99) == 0);
      apply_stimulus(ren, wen, busy, dv, g);
    end
    i_rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
